// File: rtl/sipo_frame_ctrl_if.sv
// Bundle of the serial receive side and the framed parallel side of sipo_frame_ctrl.
// With SIPO_CTRL_ERRCNT_EN defined the bundle also carries the alignment error counter.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 10
);
    logic             serial_in;
    logic             serial_valid;
    logic [WIDTH-1:0] parallel_out;
    logic             word_valid;
    logic             is_comma;
    logic             locked;
`ifdef SIPO_CTRL_ERRCNT_EN
    logic [7:0]       err_count;

    modport master (
        output serial_in, serial_valid,
        input  parallel_out, word_valid, is_comma, locked, err_count
    );
    modport slave (
        input  serial_in, serial_valid,
        output parallel_out, word_valid, is_comma, locked, err_count
    );
`else
    modport master (
        output serial_in, serial_valid,
        input  parallel_out, word_valid, is_comma, locked
    );
    modport slave (
        input  serial_in, serial_valid,
        output parallel_out, word_valid, is_comma, locked
    );
`endif
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Comma-hunting word aligner and framer for the 10-bit SIPO receive path.
// Optional saturating alignment error counter when SIPO_CTRL_ERRCNT_EN is defined.
module sipo_frame_ctrl #(
    parameter int               WIDTH    = 10,
    parameter logic [WIDTH-1:0] COMMA    = 10'b0011111010,
    parameter int               LOCK_CNT = 3,
    parameter int               LOSS_CNT = 4
) (
    input  logic            clk,
    input  logic            reinicio,
    sipo_frame_ctrl_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam int BW = $clog2(WIDTH);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0]    good_cnt_reg, good_cnt_next;
    logic [MW-1:0]    miss_cnt_reg, miss_cnt_next;
    logic [WIDTH-1:0] parallel_reg, parallel_next;
    logic             word_valid_reg, word_valid_next;
    logic             is_comma_reg, is_comma_next;
`ifdef SIPO_CTRL_ERRCNT_EN
    logic [7:0]       err_reg, err_next;
`endif

    logic [WIDTH-1:0] nxt;
    logic             hit;
    logic             on_boundary;
    logic [BW-1:0]    bit_cnt_inc;

    // Candidate shift-register contents: oldest bit ends up in the MSB.
    assign nxt[0] = bus.serial_in;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign nxt[gi] = sr_reg[gi-1];
        end
    endgenerate

    assign hit         = (nxt == COMMA) || (nxt == ~COMMA);
    assign on_boundary = (bit_cnt_reg == BIT_LAST);
    assign bit_cnt_inc = on_boundary ? '0 : bit_cnt_reg + BW'(1);

    always_ff @(posedge clk) begin
        if (reinicio) begin
            state_reg      <= SEARCH;
            sr_reg         <= '0;
            bit_cnt_reg    <= '0;
            good_cnt_reg   <= '0;
            miss_cnt_reg   <= '0;
            parallel_reg   <= '0;
            word_valid_reg <= 1'b0;
            is_comma_reg   <= 1'b0;
`ifdef SIPO_CTRL_ERRCNT_EN
            err_reg        <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            bit_cnt_reg    <= bit_cnt_next;
            good_cnt_reg   <= good_cnt_next;
            miss_cnt_reg   <= miss_cnt_next;
            parallel_reg   <= parallel_next;
            word_valid_reg <= word_valid_next;
            is_comma_reg   <= is_comma_next;
`ifdef SIPO_CTRL_ERRCNT_EN
            err_reg        <= err_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        sr_next       = sr_reg;
        bit_cnt_next  = bit_cnt_reg;
        good_cnt_next = good_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        if (bus.serial_valid) begin
            sr_next      = nxt;
            bit_cnt_next = bit_cnt_inc;
            case (state_reg)
                SEARCH: begin
                    if (hit) begin
                        state_next    = CHECK;
                        bit_cnt_next  = '0;
                        good_cnt_next = GW'(1);
                    end
                end
                CHECK: begin
                    if (hit && on_boundary) begin
                        good_cnt_next = good_cnt_reg + GW'(1);
                        if (good_cnt_reg == GOOD_LAST) begin
                            state_next    = LOCKED;
                            miss_cnt_next = '0;
                        end
                    end else if (hit) begin
                        // Comma seen at a new phase: restart alignment from it.
                        bit_cnt_next  = '0;
                        good_cnt_next = GW'(1);
                    end
                end
                LOCKED: begin
                    if (hit && on_boundary) begin
                        miss_cnt_next = '0;
                    end else if (hit) begin
                        if (miss_cnt_reg == MISS_LAST) begin
                            state_next    = SEARCH;
                            bit_cnt_next  = '0;
                            good_cnt_next = '0;
                            miss_cnt_next = '0;
                        end else begin
                            miss_cnt_next = miss_cnt_reg + MW'(1);
                        end
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // A loss edge is always off-boundary, so it can never carry a strobe.
    always_comb begin
        parallel_next   = parallel_reg;
        word_valid_next = 1'b0;
        is_comma_next   = 1'b0;
`ifdef SIPO_CTRL_ERRCNT_EN
        err_next        = err_reg;
`endif
        if (bus.serial_valid && (state_reg == LOCKED)) begin
            if (on_boundary) begin
                parallel_next   = nxt;
                word_valid_next = 1'b1;
                is_comma_next   = hit;
            end
`ifdef SIPO_CTRL_ERRCNT_EN
            if (hit && !on_boundary && (err_reg != 8'hFF)) begin
                err_next = err_reg + 8'd1;
            end
`endif
        end
    end

    assign bus.parallel_out = parallel_reg;
    assign bus.word_valid   = word_valid_reg;
    assign bus.is_comma     = is_comma_reg;
    assign bus.locked       = (state_reg == LOCKED);
`ifdef SIPO_CTRL_ERRCNT_EN
    assign bus.err_count    = err_reg;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: directed alignment scenarios plus randomized
// traffic, checked against a frame-phase reference model (SIPO_CTRL_ERRCNT_EN aware).
module tb_sipo_frame_ctrl;
    localparam int COMMA_V  = 'h0FA;
    localparam int NCOMMA_V = 'h305;

    logic clk;
    logic reinicio;

    sipo_frame_ctrl_if #(.WIDTH(10)) bus ();

    sipo_frame_ctrl dut (
        .clk      (clk),
        .reinicio (reinicio),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: frame phase is kept as the absolute bit index of the last
    // alignment anchor; a boundary is every 10th bit after it.
    int m_state  = 0;  // 0 hunting, 1 confirming, 2 locked
    int m_n      = 0;
    int m_anchor = 0;
    int m_good   = 0;
    int m_miss   = 0;
    int m_word   = 0;
    int m_par    = 0;
    int m_err    = 0;
    logic [10:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit v, input bit b);
        bit hit, bnd;
        if (r) begin
            m_state = 0; m_n = 0; m_anchor = 0; m_good = 0;
            m_miss = 0; m_word = 0; m_par = 0; m_err = 0;
            return;
        end
        if (!v) return;
        m_n++;
        m_word = ((m_word << 1) | int'(b)) & 'h3FF;
        hit = (m_word == COMMA_V) || (m_word == NCOMMA_V);
        bnd = ((m_n - m_anchor) % 10) == 0;
        case (m_state)
            0: if (hit) begin
                m_state = 1; m_anchor = m_n; m_good = 1;
            end
            1: if (hit) begin
                if (bnd) begin
                    m_good++;
                    if (m_good == 3) begin
                        m_state = 2; m_miss = 0;
                    end
                end else begin
                    m_anchor = m_n; m_good = 1;
                end
            end
            default: begin
                if (bnd) begin
                    exp_q.push_back({hit, m_word[9:0]});
                    m_par = m_word;
                end
                if (hit && bnd) m_miss = 0;
                else if (hit) begin
                    if (m_err < 255) m_err++;
                    m_miss++;
                    if (m_miss == 4) begin
                        m_state = 0; m_good = 0; m_miss = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic step(input bit r, input bit v, input bit b);
        reinicio         = r;
        bus.serial_valid = v;
        bus.serial_in    = b;
        @(posedge clk);
        model_update(r, v, b);
        #1;
    endtask

    bit stall_en = 1'b0;

    task automatic send_bit(input bit b);
        while (stall_en && ($urandom_range(0, 5) == 0))
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1, b);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    // Monitor: pops the scoreboard on every strobe and checks held outputs otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("locked", 32'(bus.locked), 32'(m_state == 2));
            if (bus.word_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got word %0h required no strobe at %0t",
                             bus.parallel_out, $time);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    chk("strobe_word", 32'(bus.parallel_out), 32'(e[9:0]));
                    chk("strobe_is_comma", 32'(bus.is_comma), 32'(e[10]));
                    $display("strobe word=%03h is_comma=%0b", bus.parallel_out, bus.is_comma);
                end
            end else begin
                chk("word_valid_low", 32'(bus.word_valid), 32'd0);
                chk("is_comma_idle", 32'(bus.is_comma), 32'd0);
                chk("missed_strobe", 32'(exp_q.size()), 32'd0);
            end
            chk("parallel_hold", 32'(bus.parallel_out), 32'(m_par));
`ifdef SIPO_CTRL_ERRCNT_EN
            chk("err_count", 32'(bus.err_count), 32'(m_err));
`endif
        end
    end

    initial begin
        reinicio         = 1'b1;
        bus.serial_valid = 1'b1;
        bus.serial_in    = 1'b0;
        mon_en           = 1'b1;

        // Reset with live serial traffic
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_parallel", 32'(bus.parallel_out), 32'd0);

        // Lock on three back-to-back commas
        send_zeros(3);
        send_word(10'h0FA);
        send_word(10'h0FA);
        for (int i = 9; i >= 1; i--) send_bit(1'(COMMA_V >> i));
        chk("lock_before_30th", 32'(bus.locked), 32'd0);
        send_bit(1'(COMMA_V & 1));
        chk("lock_after_30th", 32'(bus.locked), 32'd1);

        // Data then inverted comma
        send_word(10'h2AA);
        send_word(10'h305);

        // Stall mid-word
        for (int i = 9; i >= 6; i--) send_bit(1'(('h155 >> i) & 1));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 5; i >= 0; i--) send_bit(1'(('h155 >> i) & 1));

        // Loss by four misaligned commas, then re-lock
        send_zeros(3);
        for (int i = 0; i < 4; i++) send_word(10'h0FA);
        for (int i = 0; i < 3; i++) send_word(10'h0FA);
        send_word(10'h2AA);

        // Aligned comma after two misaligned ones keeps lock
        send_zeros(3);
        send_word(10'h0FA);
        send_word(10'h0FA);
        send_zeros(7);
        send_word(10'h0FA);
        send_zeros(3);
        send_word(10'h0FA);
        send_word(10'h0FA);
        send_zeros(7);
        send_word(10'h0FA);
        send_word(10'h155);

        // Mid-word reset while locked, then re-lock
        send_zeros(5);
        step(1'b1, 1'b1, 1'b1);
        chk("midword_rst_locked", 32'(bus.locked), 32'd0);
        for (int i = 0; i < 3; i++) send_word(10'h0FA);
        send_word(10'h3C3);

        // Randomized traffic with stalls, phase slips and occasional resets
        stall_en = 1'b1;
        for (int s = 0; s < 300; s++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 35)      send_word(($urandom_range(0, 1) != 0) ? 10'h0FA : 10'h305);
            else if (r < 85) send_word(10'($urandom_range(0, 1023)));
            else if (r < 98) begin
                int k;
                k = $urandom_range(1, 9);
                for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)));
            end else step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        stall_en = 1'b0;

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
